// File: rtl/rs_int_pkg.sv
// Shared widths, entry record and helpers for the integer reservation station.
// The MDU, LSU and BRU stations import the same package for their entry counts.
package rs_int_pkg;

    localparam int ROB_ADDR_WIDTH     = 4;
    localparam int DATA_WIDTH         = 32;
    localparam int ADDR_WIDTH         = 32;
    localparam int EXC_TYPE_WIDTH     = 3;
    localparam int OPGEN_WIDTH        = 5;

    localparam int RS_INT_ENTRY_NUM   = 4;
    localparam int RS_INT_ENTRY_WIDTH = 2;

    typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [EXC_TYPE_WIDTH-1:0] exc_t;
    typedef logic [OPGEN_WIDTH-1:0]    opgen_t;

    localparam opgen_t OPGEN_ADD = 5'd1;
    localparam opgen_t OPGEN_SUB = 5'd2;
    localparam opgen_t OPGEN_AND = 5'd3;
    localparam opgen_t OPGEN_OR  = 5'd4;
    localparam opgen_t OPGEN_XOR = 5'd5;

    // One reservation-station slot. refN=1 means dataN holds a ROB tag.
    typedef struct packed {
        logic      valid;
        rob_addr_t rob_addr;
        exc_t      exc;
        opgen_t    opgen;
        addr_t     pc;
        logic      ref1;
        logic      ref2;
        data_t     data1;
        data_t     data2;
    } rs_entry_t;

    // A tag lives in the low ROB address bits of the operand; the rest is ignored.
    function automatic logic tag_hit(input data_t data, input rob_addr_t tag);
        return data[ROB_ADDR_WIDTH-1:0] == tag;
    endfunction

endpackage

// File: rtl/rs_int_if.sv
// Bundle of the write channel, result broadcast and issue channel of rs_int.
// Issue handshake: an instruction is handed over on a rising edge where
// issue_valid=1 and fu_ready=1; while fu_ready=0 the issue fields hold steady.
interface rs_int_if;
    import rs_int_pkg::*;

    logic      flush;
    logic      rs_wen;
    rob_addr_t rob_addr_in;
    exc_t      exception_type_in;
    opgen_t    opgen_in;
    logic      operand_is_ref_1_in;
    logic      operand_is_ref_2_in;
    data_t     operand_data_1_in;
    data_t     operand_data_2_in;
    addr_t     pc_in;

    logic      cdb_valid;
    rob_addr_t cdb_rob_addr;
    data_t     cdb_data;

    logic      rs_full;

    logic      issue_valid;
    logic      fu_ready;
    rob_addr_t issue_rob_addr;
    opgen_t    issue_opgen;
    exc_t      issue_exception_type;
    addr_t     issue_pc;
    data_t     issue_operand_1;
    data_t     issue_operand_2;

    // Pipeline / environment side.
    modport master (
        output flush, rs_wen, rob_addr_in, exception_type_in, opgen_in,
               operand_is_ref_1_in, operand_is_ref_2_in,
               operand_data_1_in, operand_data_2_in, pc_in,
               cdb_valid, cdb_rob_addr, cdb_data, fu_ready,
        input  rs_full, issue_valid, issue_rob_addr, issue_opgen,
               issue_exception_type, issue_pc, issue_operand_1, issue_operand_2
    );

    // Reservation station side.
    modport slave (
        input  flush, rs_wen, rob_addr_in, exception_type_in, opgen_in,
               operand_is_ref_1_in, operand_is_ref_2_in,
               operand_data_1_in, operand_data_2_in, pc_in,
               cdb_valid, cdb_rob_addr, cdb_data, fu_ready,
        output rs_full, issue_valid, issue_rob_addr, issue_opgen,
               issue_exception_type, issue_pc, issue_operand_1, issue_operand_2
    );

endinterface

// File: rtl/rs_entry_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one.
module rs_entry_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] index
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_int.sv
// Integer reservation station: buffers instructions until both operands are
// known, snoops the CDB for tagged operands, and issues one ready entry per
// cycle through a single issue register toward the integer FU.
module rs_int
    import rs_int_pkg::*;
#(
    parameter int ENTRY_NUM        = RS_INT_ENTRY_NUM,
    parameter int ENTRY_WIDTH      = RS_INT_ENTRY_WIDTH,
    parameter bit CHECK_FULL_WRITE = 1'b1
) (
    input logic       clk,
    input logic       rst,
    rs_int_if.slave   bus
);

    rs_entry_t entry_q [ENTRY_NUM];

    logic [ENTRY_NUM-1:0]   valid_vec;
    logic [ENTRY_NUM-1:0]   free_vec;
    logic [ENTRY_NUM-1:0]   ready_vec;
    logic                   free_found;
    logic [ENTRY_WIDTH-1:0] free_idx;
    logic                   ready_found;
    logic [ENTRY_WIDTH-1:0] ready_idx;
    logic                   full;
    logic                   advance;
    logic                   issue_take;
    logic                   write_take;
    rs_entry_t              new_entry;

    logic      issue_valid_q;
    rob_addr_t issue_rob_q;
    opgen_t    issue_opgen_q;
    exc_t      issue_exc_q;
    addr_t     issue_pc_q;
    data_t     issue_op1_q;
    data_t     issue_op2_q;

    // Occupancy and readiness, all from registered entry state.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            valid_vec[i] = entry_q[i].valid;
            ready_vec[i] = entry_q[i].valid && !entry_q[i].ref1 && !entry_q[i].ref2;
        end
        free_vec = ~valid_vec;
    end

    rs_entry_select #(.N(ENTRY_NUM), .W(ENTRY_WIDTH)) u_free_select (
        .req   (free_vec),
        .found (free_found),
        .index (free_idx)
    );

    rs_entry_select #(.N(ENTRY_NUM), .W(ENTRY_WIDTH)) u_ready_select (
        .req   (ready_vec),
        .found (ready_found),
        .index (ready_idx)
    );

    // A slot freed by issue stays counted as busy this cycle, so full only
    // looks at registered valid bits and the write never lands in it.
    assign full       = &valid_vec;
    assign advance    = !issue_valid_q || bus.fu_ready;
    assign issue_take = advance && ready_found;
    assign write_take = bus.rs_wen && !full && free_found && !bus.flush;

    // Incoming instruction, with operands resolved against a same-cycle CDB hit.
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.rob_addr = bus.rob_addr_in;
        new_entry.exc      = bus.exception_type_in;
        new_entry.opgen    = bus.opgen_in;
        new_entry.pc       = bus.pc_in;
        new_entry.ref1     = bus.operand_is_ref_1_in;
        new_entry.ref2     = bus.operand_is_ref_2_in;
        new_entry.data1    = bus.operand_data_1_in;
        new_entry.data2    = bus.operand_data_2_in;
        if (bus.cdb_valid && bus.operand_is_ref_1_in &&
            tag_hit(bus.operand_data_1_in, bus.cdb_rob_addr)) begin
            new_entry.ref1  = 1'b0;
            new_entry.data1 = bus.cdb_data;
        end
        if (bus.cdb_valid && bus.operand_is_ref_2_in &&
            tag_hit(bus.operand_data_2_in, bus.cdb_rob_addr)) begin
            new_entry.ref2  = 1'b0;
            new_entry.data2 = bus.cdb_data;
        end
    end

    // Entry array: flush, write into the lowest free slot, free on issue, CDB wakeup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (write_take && free_idx == ENTRY_WIDTH'(i)) begin
                    entry_q[i] <= new_entry;
                end else if (entry_q[i].valid) begin
                    if (issue_take && ready_idx == ENTRY_WIDTH'(i)) begin
                        entry_q[i].valid <= 1'b0;
                    end
                    if (bus.cdb_valid && entry_q[i].ref1 &&
                        tag_hit(entry_q[i].data1, bus.cdb_rob_addr)) begin
                        entry_q[i].ref1  <= 1'b0;
                        entry_q[i].data1 <= bus.cdb_data;
                    end
                    if (bus.cdb_valid && entry_q[i].ref2 &&
                        tag_hit(entry_q[i].data2, bus.cdb_rob_addr)) begin
                        entry_q[i].ref2  <= 1'b0;
                        entry_q[i].data2 <= bus.cdb_data;
                    end
                end
            end
        end
    end

    // Issue register: reload from the lowest ready entry whenever it may advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid_q <= 1'b0;
            issue_rob_q   <= '0;
            issue_opgen_q <= '0;
            issue_exc_q   <= '0;
            issue_pc_q    <= '0;
            issue_op1_q   <= '0;
            issue_op2_q   <= '0;
        end else if (bus.flush) begin
            issue_valid_q <= 1'b0;
        end else if (advance) begin
            issue_valid_q <= ready_found;
            if (ready_found) begin
                issue_rob_q   <= entry_q[ready_idx].rob_addr;
                issue_opgen_q <= entry_q[ready_idx].opgen;
                issue_exc_q   <= entry_q[ready_idx].exc;
                issue_pc_q    <= entry_q[ready_idx].pc;
                issue_op1_q   <= entry_q[ready_idx].data1;
                issue_op2_q   <= entry_q[ready_idx].data2;
            end
        end
    end

    assign bus.rs_full              = full;
    assign bus.issue_valid          = issue_valid_q;
    assign bus.issue_rob_addr       = issue_rob_q;
    assign bus.issue_opgen          = issue_opgen_q;
    assign bus.issue_exception_type = issue_exc_q;
    assign bus.issue_pc             = issue_pc_q;
    assign bus.issue_operand_1      = issue_op1_q;
    assign bus.issue_operand_2      = issue_op2_q;

    // Writing into a full station is a protocol error on the II side.
    full_write_check: assert property (@(posedge clk) disable iff (!rst)
        !(CHECK_FULL_WRITE && bus.rs_wen && full && !bus.flush))
        else $error("rs_int: write while full");

endmodule

// File: tb/tb_rs_int.sv
// Bench for rs_int: directed multi-cycle sequences plus a table of writes,
// with every issued instruction checked against an expected queue.
module tb_rs_int;
    import rs_int_pkg::*;

    typedef struct packed {
        rob_addr_t rob;
        opgen_t    opgen;
        exc_t      exc;
        addr_t     pc;
        data_t     op1;
        data_t     op2;
    } exp_t;

    typedef struct {
        rob_addr_t rob;
        opgen_t    opgen;
        exc_t      exc;
        addr_t     pc;
        logic      r1;
        logic      r2;
        data_t     d1;
        data_t     d2;
        logic      cdb_v;
        rob_addr_t cdb_rob;
        data_t     cdb_data;
        data_t     exp1;
        data_t     exp2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    rs_int_if bus();

    rs_int #(
        .ENTRY_NUM        (4),
        .ENTRY_WIDTH      (2),
        .CHECK_FULL_WRITE (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rs_wen    = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic drive_write(input rob_addr_t rob, input opgen_t opg, input exc_t exc,
                               input addr_t pc, input logic r1, input logic r2,
                               input data_t d1, input data_t d2);
        bus.rs_wen              = 1'b1;
        bus.rob_addr_in         = rob;
        bus.opgen_in            = opg;
        bus.exception_type_in   = exc;
        bus.pc_in               = pc;
        bus.operand_is_ref_1_in = r1;
        bus.operand_is_ref_2_in = r2;
        bus.operand_data_1_in   = d1;
        bus.operand_data_2_in   = d2;
    endtask

    task automatic set_cdb(input rob_addr_t rob, input data_t data);
        bus.cdb_valid    = 1'b1;
        bus.cdb_rob_addr = rob;
        bus.cdb_data     = data;
    endtask

    task automatic push_exp(input rob_addr_t rob, input opgen_t opg, input exc_t exc,
                            input addr_t pc, input data_t op1, input data_t op2);
        exp_q.push_back('{rob: rob, opgen: opg, exc: exc, pc: pc, op1: op1, op2: op2});
    endtask

    // Scoreboard: an instruction leaves the issue register on an edge with
    // issue_valid && fu_ready; compare it against the oldest expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rst && bus.issue_valid && bus.fu_ready) begin
            got = '{rob: bus.issue_rob_addr, opgen: bus.issue_opgen,
                    exc: bus.issue_exception_type, pc: bus.issue_pc,
                    op1: bus.issue_operand_1, op2: bus.issue_operand_2};
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_issue: got rob %0d op1 0x%0h, expected no issue",
                         got.rob, got.op1);
            end else begin
                e = exp_q.pop_front();
                if (got === e) pass_cnt++;
                else $display("FAIL issue_rec: got rob %0d opg %0d exc %0d pc 0x%0h op 0x%0h/0x%0h, expected rob %0d opg %0d exc %0d pc 0x%0h op 0x%0h/0x%0h",
                              got.rob, got.opgen, got.exc, got.pc, got.op1, got.op2,
                              e.rob, e.opgen, e.exc, e.pc, e.op1, e.op2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: ready writes, bypasses (incl. tag in low bits only) and a CDB
        // that must not disturb a non-ref operand.
        vecs[0] = '{4'd1, OPGEN_ADD, 3'd0, 32'h100, 0, 0, 32'd10, 32'd20, 0, 4'd0, 32'd0, 32'd10, 32'd20};
        vecs[1] = '{4'd2, OPGEN_SUB, 3'd1, 32'h104, 1, 0, 32'hFFFF_FFF3, 32'd4, 1, 4'd3, 32'hC0DE, 32'hC0DE, 32'd4};
        vecs[2] = '{4'd3, OPGEN_AND, 3'd2, 32'h108, 0, 0, 32'd3, 32'd8, 1, 4'd3, 32'hBAD, 32'd3, 32'd8};
        vecs[3] = '{4'd4, OPGEN_OR,  3'd3, 32'h10C, 1, 1, 32'd9, 32'h19, 1, 4'd9, 32'h99, 32'h99, 32'h99};
        vecs[4] = '{4'd5, OPGEN_XOR, 3'd4, 32'h110, 0, 1, 32'd1, 32'h0000_00F7, 1, 4'd7, 32'h77, 32'd1, 32'h77};
        vecs[5] = '{4'd15, OPGEN_ADD, 3'd7, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFF, 32'd0, 0, 4'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 6; i++) vecs[i].pc = vecs[i].pc + 32'($urandom_range(0, 15)) * 32'h1000;

        bus.flush = 0; bus.rs_wen = 0; bus.rob_addr_in = 0; bus.exception_type_in = 0;
        bus.opgen_in = 0; bus.operand_is_ref_1_in = 0; bus.operand_is_ref_2_in = 0;
        bus.operand_data_1_in = 0; bus.operand_data_2_in = 0; bus.pc_in = 0;
        bus.cdb_valid = 0; bus.cdb_rob_addr = 0; bus.cdb_data = 0; bus.fu_ready = 1;

        // Reset state
        #12;
        check("rst_issue_valid", 32'(bus.issue_valid), 0);
        check("rst_full", 32'(bus.rs_full), 0);
        check("rst_op1", bus.issue_operand_1, 0);
        check("rst_rob", 32'(bus.issue_rob_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: ready write issues after two edges
        drive_write(4'd1, OPGEN_ADD, 3'd0, 32'h40, 0, 0, 32'd5, 32'd7);
        push_exp(4'd1, OPGEN_ADD, 3'd0, 32'h40, 32'd5, 32'd7);
        tick();
        check("t1_not_yet", 32'(bus.issue_valid), 0);
        tick();
        check("t1_issue_valid", 32'(bus.issue_valid), 1);
        check("t1_op1", bus.issue_operand_1, 32'd5);
        check("t1_op2", bus.issue_operand_2, 32'd7);
        check("t1_rob", 32'(bus.issue_rob_addr), 1);
        tick();

        // 2: wait on tag 3, wake after three idle cycles
        drive_write(4'd2, OPGEN_SUB, 3'd0, 32'h44, 1, 0, 32'd3, 32'd9);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_waiting", 32'(bus.issue_valid), 0);
        end
        set_cdb(4'd3, 32'hAA);
        push_exp(4'd2, OPGEN_SUB, 3'd0, 32'h44, 32'hAA, 32'd9);
        tick();
        check("t2_wake_edge", 32'(bus.issue_valid), 0);
        tick();
        check("t2_issue_valid", 32'(bus.issue_valid), 1);
        check("t2_op1", bus.issue_operand_1, 32'hAA);
        tick();

        // 3: write bypass from a same-cycle broadcast
        drive_write(4'd4, OPGEN_AND, 3'd0, 32'h48, 0, 1, 32'h11, 32'd6);
        set_cdb(4'd6, 32'h55);
        push_exp(4'd4, OPGEN_AND, 3'd0, 32'h48, 32'h11, 32'h55);
        tick();
        check("t3_not_yet", 32'(bus.issue_valid), 0);
        tick();
        check("t3_issue_valid", 32'(bus.issue_valid), 1);
        check("t3_op2", bus.issue_operand_2, 32'h55);
        tick();

        // 4: fill, ignored fifth write, wake entry 2
        for (int k = 0; k < 4; k++) begin
            drive_write(rob_addr_t'(12 + k), OPGEN_SUB, 3'd1, 32'h200 + 32'(k * 4), 1, 0,
                        data_t'(8 + k), data_t'(32'h30 + k));
            tick();
        end
        check("t4_full", 32'(bus.rs_full), 1);
        drive_write(4'd7, OPGEN_ADD, 3'd0, 32'h300, 0, 0, 32'd1, 32'd2);
        tick();
        check("t4_still_full", 32'(bus.rs_full), 1);
        check("t4_no_issue", 32'(bus.issue_valid), 0);
        set_cdb(4'd10, 32'h22);
        push_exp(4'd14, OPGEN_SUB, 3'd1, 32'h208, 32'h22, 32'h32);
        tick();
        check("t4_wake_full", 32'(bus.rs_full), 1);
        tick();
        check("t4_issue_valid", 32'(bus.issue_valid), 1);
        check("t4_issue_rob", 32'(bus.issue_rob_addr), 14);
        check("t4_full_drops", 32'(bus.rs_full), 0);
        set_cdb(4'd8, 32'h80);
        push_exp(4'd12, OPGEN_SUB, 3'd1, 32'h200, 32'h80, 32'h30);
        tick();
        set_cdb(4'd9, 32'h90);
        push_exp(4'd13, OPGEN_SUB, 3'd1, 32'h204, 32'h90, 32'h31);
        tick();
        set_cdb(4'd11, 32'hB0);
        push_exp(4'd15, OPGEN_SUB, 3'd1, 32'h20C, 32'hB0, 32'h33);
        tick();
        tick();
        tick();
        check("t4_drained", 32'(bus.issue_valid), 0);

        // 5: hold with fu_ready=0, then release in index order
        bus.fu_ready = 1'b0;
        drive_write(4'd1, OPGEN_OR, 3'd2, 32'h400, 0, 0, 32'hA1, 32'hA2);
        push_exp(4'd1, OPGEN_OR, 3'd2, 32'h400, 32'hA1, 32'hA2);
        tick();
        tick();
        drive_write(4'd2, OPGEN_XOR, 3'd3, 32'h404, 0, 0, 32'hB1, 32'hB2);
        push_exp(4'd2, OPGEN_XOR, 3'd3, 32'h404, 32'hB1, 32'hB2);
        tick();
        drive_write(4'd3, OPGEN_ADD, 3'd4, 32'h408, 0, 0, 32'hC1, 32'hC2);
        push_exp(4'd3, OPGEN_ADD, 3'd4, 32'h408, 32'hC1, 32'hC2);
        tick();
        tick();
        tick();
        check("t5_hold_valid", 32'(bus.issue_valid), 1);
        check("t5_hold_rob", 32'(bus.issue_rob_addr), 1);
        check("t5_hold_op1", bus.issue_operand_1, 32'hA1);
        bus.fu_ready = 1'b1;
        tick();
        check("t5_second_rob", 32'(bus.issue_rob_addr), 2);
        tick();
        check("t5_third_rob", 32'(bus.issue_rob_addr), 3);
        tick();
        check("t5_empty", 32'(bus.issue_valid), 0);

        // 6: flush with full station, held issue and a concurrent write
        bus.fu_ready = 1'b0;
        drive_write(4'd5, OPGEN_ADD, 3'd0, 32'h500, 0, 0, 32'd1, 32'd1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            drive_write(rob_addr_t'(6 + k), OPGEN_SUB, 3'd0, 32'h504, 0, 0, 32'd2, 32'd3);
            tick();
        end
        check("t6_pre_full", 32'(bus.rs_full), 1);
        check("t6_pre_valid", 32'(bus.issue_valid), 1);
        drive_write(4'd10, OPGEN_AND, 3'd0, 32'h520, 0, 0, 32'd4, 32'd4);
        bus.flush = 1'b1;
        tick();
        check("t6_flush_valid", 32'(bus.issue_valid), 0);
        check("t6_flush_full", 32'(bus.rs_full), 0);
        exp_q.delete();
        bus.fu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_stale", 32'(bus.issue_valid), 0);
        end

        // Table of writes at one per cycle
        for (int i = 0; i < 6; i++) begin
            drive_write(vecs[i].rob, vecs[i].opgen, vecs[i].exc, vecs[i].pc,
                        vecs[i].r1, vecs[i].r2, vecs[i].d1, vecs[i].d2);
            if (vecs[i].cdb_v) set_cdb(vecs[i].cdb_rob, vecs[i].cdb_data);
            push_exp(vecs[i].rob, vecs[i].opgen, vecs[i].exc, vecs[i].pc,
                     vecs[i].exp1, vecs[i].exp2);
            tick();
            check("tbl_not_full", 32'(bus.rs_full), 0);
        end
        for (int k = 0; k < 4; k++) tick();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
